// File: rtl/aurora_pkg.sv
// Shared Aurora 64b/66b receive types: frame geometry, sync header codes, alignment FSM states.
package aurora_pkg;
    localparam int         FRAME_W  = 66;
    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} align_state_t;

    function automatic logic hdr_valid(input logic [1:0] h);
        return (h == HDR_DATA) || (h == HDR_CTRL);
    endfunction
endpackage

// File: rtl/block_aligner_if.sv
// Gearbox/locator input side and aligned payload output side of the block aligner.
interface block_aligner_if #(
    parameter int BUF_W = 194,
    parameter int CNT_W = 6,
    parameter int OFF_W = 7
);
    logic [BUF_W-1:0] gbox_buffer;
    logic [CNT_W-1:0] gbox_cnt;
    logic             buffer_dv;
    logic             is_synced;
    logic [OFF_W-1:0] offset_pos;
    logic [63:0]      data_o;
    logic [1:0]       hdr_o;
    logic             data_valid_o;
    logic             locked_o;
    logic             rehunt_o;
    logic [15:0]      bad_hdr_cnt_o;

    modport master (
        output gbox_buffer, gbox_cnt, buffer_dv, is_synced, offset_pos,
        input  data_o, hdr_o, data_valid_o, locked_o, rehunt_o, bad_hdr_cnt_o
    );
    modport slave (
        input  gbox_buffer, gbox_cnt, buffer_dv, is_synced, offset_pos,
        output data_o, hdr_o, data_valid_o, locked_o, rehunt_o, bad_hdr_cnt_o
    );
endinterface

// File: rtl/descrambler64.sv
// Self-synchronous x^58+x^39+1 descrambler, 64 bits per enable, bit 0 is first on the wire.
module descrambler64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en,
    input  logic [63:0] din,
    output logic [63:0] dout
);
    // hist holds the previous 58 scrambled bits, oldest at bit 0
    logic [57:0]  hist;
    logic [121:0] ext;

    assign ext  = {din, hist};
    assign dout = din ^ ext[63:0] ^ ext[82:19];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)  hist <= '0;
        else if (en) hist <= din[63:6];
    end
endmodule

// File: rtl/block_aligner.sv
// Cuts 66-bit frames at the locator offset, checks sync headers, runs hunt/verify/locked and descrambles.
module block_aligner
    import aurora_pkg::*;
#(
    parameter int BUF_W    = 194,
    parameter int CNT_W    = 6,
    parameter int OFF_W    = 7,
    parameter int SKIP_CNT = 32,
    parameter int LOCK_CNT = 32,
    parameter int WIN      = 64,
    parameter int BAD_MAX  = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    block_aligner_if.slave   bus
);
    localparam int GOOD_W = $clog2(LOCK_CNT);
    localparam int WIN_W  = $clog2(WIN);
    localparam int BAD_W  = $clog2(BAD_MAX + 1);
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(66);

    align_state_t       state;
    logic [OFF_W-1:0]   off_q;
    logic               fe, legal;
    logic [FRAME_W-1:0] frame;
    logic               s1_vld, s1_sync, s1_legal, s1_ok;
    logic [1:0]         s1_hdr;
    logic [63:0]        s1_pay, descr;
    logic [GOOD_W-1:0]  good_q;
    logic [WIN_W-1:0]   win_q;
    logic [BAD_W-1:0]   bad_q, bad_nxt;
    logic [63:0]        data_q;
    logic [1:0]         hdr_q;
    logic               dv_q, locked_q, rehunt_q;
    logic [15:0]        bad_cnt_q;

    assign fe      = bus.buffer_dv && (bus.gbox_cnt != CNT_W'(SKIP_CNT));
    assign legal   = bus.offset_pos <= OFF_MAX;
    assign frame   = FRAME_W'(bus.gbox_buffer >> off_q);
    assign s1_ok   = hdr_valid(s1_hdr);
    assign bad_nxt = bad_q + 1'b1;

    // Offset tracks the locator only while hunting; frozen once a candidate is under test.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            off_q <= '0;
        else if (state == HUNT && bus.is_synced && legal)
            off_q <= bus.offset_pos;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_vld   <= 1'b0;
            s1_hdr   <= '0;
            s1_pay   <= '0;
            s1_sync  <= 1'b0;
            s1_legal <= 1'b0;
        end else begin
            s1_vld <= fe;
            if (fe) begin
                s1_hdr   <= frame[1:0];
                s1_pay   <= frame[65:2];
                s1_sync  <= bus.is_synced;
                s1_legal <= legal;
            end
        end
    end

    // Runs in every state so the history is already trained when lock is declared.
    descrambler64 u_descr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (s1_vld),
        .din   (s1_pay),
        .dout  (descr)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= HUNT;
            good_q    <= '0;
            win_q     <= '0;
            bad_q     <= '0;
            data_q    <= '0;
            hdr_q     <= '0;
            dv_q      <= 1'b0;
            locked_q  <= 1'b0;
            rehunt_q  <= 1'b0;
            bad_cnt_q <= '0;
        end else begin
            dv_q     <= 1'b0;
            rehunt_q <= 1'b0;
            if (s1_vld) begin
                unique case (state)
                    HUNT: if (s1_sync && s1_legal) begin
                        state  <= VERIFY;
                        good_q <= '0;
                    end
                    VERIFY: begin
                        if (!s1_sync) begin
                            state <= HUNT;
                        end else if (!s1_ok) begin
                            state    <= HUNT;
                            rehunt_q <= 1'b1;
                        end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                            win_q    <= '0;
                            bad_q    <= '0;
                        end else begin
                            good_q <= good_q + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (s1_ok) begin
                            dv_q   <= 1'b1;
                            data_q <= descr;
                            hdr_q  <= s1_hdr;
                        end else if (bad_cnt_q != 16'hFFFF) begin
                            bad_cnt_q <= bad_cnt_q + 1'b1;
                        end
                        // Loss of lock wins over the window rollover on the same frame.
                        if (!s1_ok && bad_nxt >= BAD_W'(BAD_MAX)) begin
                            state    <= HUNT;
                            locked_q <= 1'b0;
                            rehunt_q <= 1'b1;
                        end else if (win_q == WIN_W'(WIN - 1)) begin
                            win_q <= '0;
                            bad_q <= '0;
                        end else begin
                            win_q <= win_q + 1'b1;
                            if (!s1_ok) bad_q <= bad_nxt;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.data_o        = data_q;
    assign bus.hdr_o         = hdr_q;
    assign bus.data_valid_o  = dv_q;
    assign bus.locked_o      = locked_q;
    assign bus.rehunt_o      = rehunt_q;
    assign bus.bad_hdr_cnt_o = bad_cnt_q;
endmodule

// File: tb/tb_block_aligner.sv
// Random-stimulus bench for block_aligner: frames are scrambled here and checked against a per-frame lock model.
module tb_block_aligner;
    import aurora_pkg::*;

    localparam int BUF_W = 194;
    localparam int CNT_W = 6;
    localparam int OFF_W = 7;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    block_aligner_if #(.BUF_W(BUF_W), .CNT_W(CNT_W), .OFF_W(OFF_W)) bus ();

    block_aligner dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        vld;
        logic [63:0] data;
        logic [1:0]  hdr;
        logic        lck;
        logic        rh;
        logic [15:0] bcnt;
    } ev_t;
    ev_t evq[$];

    logic [63:0] e_data;
    logic [1:0]  e_hdr;
    logic        e_vld, e_lck, e_rh;
    logic [15:0] e_bcnt;

    // reference lock model, one step per frame
    align_state_t m_st;
    int m_good, m_win, m_bad, m_bcnt;
    logic [57:0] sh = '0;   // line scrambler history, sh[0] most recent
    int place = 17;         // where the true frame sits in the buffer

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic scramble(input logic [63:0] d, output logic [63:0] s);
        for (int i = 0; i < 64; i++) begin
            s[i] = d[i] ^ sh[57] ^ sh[38];
            sh   = {sh[56:0], s[i]};
        end
    endtask

    task automatic model_frame(input logic [1:0] hdr, input logic sync, input logic [6:0] off,
                               input logic [63:0] plain);
        ev_t e;
        logic ok;
        ok = (hdr == 2'b01) || (hdr == 2'b10);
        e.due = cyc + 2; e.vld = 1'b0; e.data = '0; e.hdr = '0; e.rh = 1'b0;
        case (m_st)
            HUNT: if (sync && off <= 66) begin m_st = VERIFY; m_good = 0; end
            VERIFY: begin
                if (!sync) m_st = HUNT;
                else if (!ok) begin m_st = HUNT; e.rh = 1'b1; end
                else begin
                    m_good++;
                    if (m_good == 32) begin m_st = LOCKED; m_win = 0; m_bad = 0; end
                end
            end
            default: begin
                if (ok) begin e.vld = 1'b1; e.data = plain; e.hdr = hdr; end
                else begin
                    m_bad++;
                    if (m_bcnt < 65535) m_bcnt++;
                end
                m_win++;
                if (m_bad >= 16) begin m_st = HUNT; e.rh = 1'b1; end
                else if (m_win == 64) begin m_win = 0; m_bad = 0; end
            end
        endcase
        e.lck  = (m_st == LOCKED);
        e.bcnt = 16'(m_bcnt);
        evq.push_back(e);
    endtask

    task automatic check_out();
        ev_t e;
        e_vld = 1'b0;
        e_rh  = 1'b0;
        while (evq.size() > 0 && evq[0].due == cyc) begin
            e = evq.pop_front();
            e_vld = e.vld; e_rh = e.rh; e_lck = e.lck; e_bcnt = e.bcnt;
            if (e.vld) begin e_data = e.data; e_hdr = e.hdr; end
        end
        chk("data_valid", 64'(bus.data_valid_o), 64'(e_vld));
        chk("data", bus.data_o, e_data);
        chk("hdr", 64'(bus.hdr_o), 64'(e_hdr));
        chk("locked", 64'(bus.locked_o), 64'(e_lck));
        chk("rehunt", 64'(bus.rehunt_o), 64'(e_rh));
        chk("bad_cnt", 64'(bus.bad_hdr_cnt_o), 64'(e_bcnt));
    endtask

    task automatic tick(input logic dv, input logic [5:0] cnt, input logic sync,
                        input logic [6:0] off, input logic [1:0] hdr);
        logic [223:0] r;
        logic [BUF_W-1:0] b;
        logic [63:0] plain, s;
        logic fe;
        @(posedge clk_i); #1;
        for (int k = 0; k < 7; k++) r[k*32 +: 32] = $urandom;
        b  = r[BUF_W-1:0];
        fe = dv && (cnt != 6'd32);
        plain = {$urandom, $urandom};
        if (fe) begin
            scramble(plain, s);
            b[place +: 66] = {s, hdr};
        end
        bus.gbox_buffer = b;
        bus.gbox_cnt    = cnt;
        bus.buffer_dv   = dv;
        bus.is_synced   = sync;
        bus.offset_pos  = off;
        if (rst_i && fe) model_frame(hdr, sync, off, plain);
        @(negedge clk_i);
        check_out();
    endtask

    function automatic logic [1:0] rand_hdr();
        return $urandom_range(1) ? 2'b01 : 2'b10;
    endfunction

    // one frame event, sometimes followed by an idle or gearbox-stall cycle
    task automatic frame(input logic [1:0] hdr, input logic sync, input logic [6:0] off);
        logic [5:0] c;
        c = 6'($urandom_range(63));
        if (c == 6'd32) c = 6'd0;
        tick(1'b1, c, sync, off, hdr);
        if ($urandom_range(3) == 0) begin
            if ($urandom_range(1) == 1) tick(1'b0, 6'($urandom_range(63)), sync, off, rand_hdr());
            else                        tick(1'b1, 6'd32, sync, off, rand_hdr());
        end
    endtask

    task automatic flush();
        repeat (3) tick(1'b0, 6'd0, 1'b1, 7'(place), 2'b01);
    endtask

    task automatic do_reset(input int n);
        #2 rst_i = 1'b0;
        #1;
        evq.delete();
        m_st = HUNT; m_good = 0; m_win = 0; m_bad = 0; m_bcnt = 0;
        e_data = '0; e_hdr = '0; e_vld = 1'b0; e_lck = 1'b0; e_rh = 1'b0; e_bcnt = '0;
        chk("rst_async_valid", 64'(bus.data_valid_o), 64'd0);
        chk("rst_async_locked", 64'(bus.locked_o), 64'd0);
        chk("rst_async_data", bus.data_o, 64'd0);
        chk("rst_async_bcnt", 64'(bus.bad_hdr_cnt_o), 64'd0);
        repeat (n) tick(1'($urandom_range(1)), 6'($urandom_range(63)), 1'($urandom_range(1)),
                        7'($urandom_range(127)), 2'($urandom_range(3)));
        rst_i = 1'b1;
    endtask

    // 64 frames with nbad invalid headers at shuffled positions
    task automatic send_window(input int nbad);
        logic flags [64];
        logic t;
        int j;
        for (int k = 0; k < 64; k++) flags[k] = (k < nbad);
        for (int k = 63; k > 0; k--) begin
            j = $urandom_range(k);
            t = flags[k]; flags[k] = flags[j]; flags[j] = t;
        end
        for (int k = 0; k < 64; k++) frame(flags[k] ? 2'b11 : rand_hdr(), 1'b1, 7'(place));
    endtask

    initial begin
        bus.gbox_buffer = '0; bus.gbox_cnt = '0; bus.buffer_dv = 1'b0;
        bus.is_synced = 1'b0; bus.offset_pos = '0;

        // reset under random inputs, then frames with no sync
        do_reset(5);
        place = 17;
        repeat (10) frame(rand_hdr(), 1'b0, 7'd17);

        // lock at offset 17, then locator wanders while locked
        repeat (40) frame(rand_hdr(), 1'b1, 7'd17);
        repeat (20) frame(rand_hdr(), 1'($urandom_range(1)), 7'($urandom_range(127)));
        flush();
        chk("lock_hold", 64'(bus.locked_o), 64'd1);

        // async reset while locked, then verify failure and sync drop during verify
        do_reset(3);
        frame(2'b01, 1'b1, 7'd17);
        repeat (9) frame(rand_hdr(), 1'b1, 7'd17);
        frame(2'b00, 1'b1, 7'd17);
        repeat (3) frame(rand_hdr(), 1'b1, 7'd17);
        frame(rand_hdr(), 1'b0, 7'd17);
        repeat (40) frame(rand_hdr(), 1'b1, 7'd17);
        flush();
        chk("relock", 64'(bus.locked_o), 64'd1);

        // 16 bad headers inside one window
        do_reset(2);
        repeat (33) frame(rand_hdr(), 1'b1, 7'd17);
        send_window(16);
        flush();
        chk("lol_bcnt", 64'(bus.bad_hdr_cnt_o), 64'd16);
        chk("lol_lock", 64'(bus.locked_o), 64'd0);

        // 15 bad per window over 4 windows
        do_reset(2);
        repeat (33) frame(rand_hdr(), 1'b1, 7'd17);
        repeat (4) send_window(15);
        flush();
        chk("w4_bcnt", 64'(bus.bad_hdr_cnt_o), 64'd60);
        chk("w4_lock", 64'(bus.locked_o), 64'd1);

        // largest legal offset
        do_reset(2);
        place = 66;
        repeat (40) frame(rand_hdr(), 1'b1, 7'd66);
        flush();
        chk("off66_lock", 64'(bus.locked_o), 64'd1);

        // illegal offset never latches
        do_reset(2);
        place = 67;
        repeat (50) frame(rand_hdr(), 1'b1, 7'd67);
        flush();
        chk("off67_lock", 64'(bus.locked_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
